// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx_ctrl among NUM_REQ byte streams, with optional message lock.
// Define UART_TX_ARB_CRLF_EN to follow every transmitted 0x0D with an inserted 0x0A.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int PKT_LOCK = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

`ifdef UART_TX_ARB_CRLF_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DRAIN, ST_LF} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DRAIN} state_t;
`endif

  state_t               state_q, state_d;
  logic                 tx_send_q, tx_send_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 lock_q, lock_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   ready_d;
`ifdef UART_TX_ARB_CRLF_EN
  logic                 last_q, last_d;
  logic                 lf_q, lf_d;
`endif

  logic [NUM_REQ-1:0]   cand;
  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;

  // While locked only the owner may win; search starts just after the last winner.
  always_comb begin
    int idx;
    idx       = 0;
    cand      = lock_q ? (req_valid & grant_q) : req_valid;
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_send_d = tx_send_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    lock_d    = lock_q;
    rr_ptr_d  = rr_ptr_q;
    ready_d   = '0;
`ifdef UART_TX_ARB_CRLF_EN
    last_d    = last_q;
    lf_d      = lf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_ready && win_found) begin
          ready_d[win_idx] = 1'b1;
          tx_data_d        = req_data[8*win_idx +: 8];
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          rr_ptr_d         = win_idx;
          lock_d           = (PKT_LOCK != 0) && !req_last[win_idx];
`ifdef UART_TX_ARB_CRLF_EN
          // A CR keeps the lock until its LF has gone out.
          if (req_data[8*win_idx +: 8] == 8'h0D) lock_d = (PKT_LOCK != 0);
          last_d           = req_last[win_idx];
`endif
          tx_send_d        = 1'b1;
          state_d          = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_ready) begin
          tx_send_d = 1'b0;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tx_ready) begin
`ifdef UART_TX_ARB_CRLF_EN
          if (tx_data_q == 8'h0D) begin
            state_d = ST_LF;
          end else begin
            state_d = ST_IDLE;
            if (lf_q) begin
              lock_d = lock_q && !last_q;
              lf_d   = 1'b0;
            end
            if (!lock_d) grant_d = '0;
          end
`else
          state_d = ST_IDLE;
          if (!lock_q) grant_d = '0;
`endif
        end
      end
`ifdef UART_TX_ARB_CRLF_EN
      ST_LF: begin
        tx_data_d = 8'h0A;
        tx_send_d = 1'b1;
        lf_d      = 1'b1;
        state_d   = ST_SEND;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'h00;
      grant_q   <= '0;
      lock_q    <= 1'b0;
      rr_ptr_q  <= PTR_RST;
`ifdef UART_TX_ARB_CRLF_EN
      last_q    <= 1'b0;
      lf_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      lock_q    <= lock_d;
      rr_ptr_q  <= rr_ptr_d;
`ifdef UART_TX_ARB_CRLF_EN
      last_q    <= last_d;
      lf_q      <= lf_d;
`endif
    end
  end

  // Acceptance is suppressed while reset is held so no byte is taken on the release edge.
  assign req_ready = ready_d & {NUM_REQ{rst_n}};
  assign tx_send   = tx_send_q;
  assign tx_data   = tx_data_q;
  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE) || lock_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic, checked against a
// message-level model (round-robin winner rule, lock ownership, queue of expected UART bytes).
module tb_uart_tx_arbiter;
  localparam int NR = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*NR-1:0] req_data;
  logic            tx_send, tx_ready, busy;
  logic [7:0]      tx_data;

  uart_tx_arbiter #(.NUM_REQ(NR), .PKT_LOCK(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_send(tx_send), .tx_data(tx_data),
    .tx_ready(tx_ready), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // UART transmitter model: takes tx_data when idle and send=1, then busy for frame_len cycles.
  int         frame_len = 10;
  int         frame_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] uart_log[$];
  assign tx_ready = (frame_cnt == 0);

  always @(posedge clk) begin
    if (frame_cnt > 0) begin
      frame_cnt <= frame_cnt - 1;
    end else if (tx_send) begin
      frame_cnt <= frame_len;
      uart_log.push_back(tx_data);
      chk("uart_byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("uart_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  // Requester sources: {last, data} per entry.
  logic [8:0]    src_q[NR][$];
  logic [NR-1:0] en_mask;
  bit            rnd_gate;
  int            acc_cnt[NR];
  int            m_ptr, m_owner;
  bit            m_lock;
  int            send_len;
  logic [7:0]    send_data;

  task automatic tick();
    logic [NR-1:0] cand;
    int win;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() != 0 && en_mask[i] && (!rnd_gate || $urandom_range(3) != 0)) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_q[i][0][7:0];
        req_last[i]        = src_q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
    #1;
    if (rst_n) begin
      if (tx_send) begin
        if (send_len > 0) chk("tx_data_stable", 32'(tx_data), 32'(send_data));
        else send_data = tx_data;
        send_len++;
      end else if (send_len > 0) begin
        chk("tx_send_len", send_len, 32'd2);
        send_len = 0;
      end
      if (m_lock) begin
        chk("grant_locked_owner", 32'(grant), 32'(onehot(m_owner)));
        chk("busy_locked", 32'(busy), 32'd1);
      end
      cand = m_lock ? (req_valid & onehot(m_owner)) : req_valid;
      if (req_ready != '0) begin
        win = -1;
        for (int k = 1; k <= NR; k++)
          if (win < 0 && cand[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
        chk("ready_needs_tx_idle", 32'(tx_ready), 32'd1);
        chk("ready_not_in_send", 32'(tx_send), 32'd0);
        if (win < 0) begin
          chk("ready_without_candidate", 32'(req_ready), 32'd0);
        end else begin
          chk("rr_winner", 32'(req_ready), 32'(onehot(win)));
          exp_q.push_back(src_q[win][0][7:0]);
`ifdef UART_TX_ARB_CRLF_EN
          if (src_q[win][0][7:0] == 8'h0D) exp_q.push_back(8'h0A);
`endif
          m_lock  = !src_q[win][0][8];
          m_owner = win;
          m_ptr   = win;
          acc_cnt[win]++;
          void'(src_q[win].pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && (src_q[2].size() == 0) &&
             (exp_q.size() == 0) && !busy && tx_ready && !tx_send;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int         n, c61, c62, tot, acc0;
    logic [7:0] t4_bytes[5];
    logic [7:0] b;
    int         len;

    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    en_mask = '1; rnd_gate = 1'b0; m_ptr = NR - 1; m_lock = 1'b0; m_owner = 0;
    send_len = 0; send_data = 8'h00;
    for (int i = 0; i < NR; i++) acc_cnt[i] = 0;

    // T1: reset values, then reset asserted mid-SEND
    src_q[0].push_back({1'b1, 8'h5A});
    repeat (3) tick();
    chk("rst_tx_send", 32'(tx_send), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("t1_mid_send", 32'(tx_send), 32'd1);
    chk("t1_grant_mid", 32'(grant), 32'b001);
    rst_n = 1'b0;
    #1;
    chk("t1_async_tx_send", 32'(tx_send), 32'd0);
    chk("t1_async_grant", 32'(grant), 32'd0);
    chk("t1_async_req_ready", 32'(req_ready), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    m_ptr = NR - 1; m_lock = 1'b0; send_len = 0;
    tick();
    rst_n = 1'b1;
    src_q[1].push_back({1'b1, 8'h33});
    run_until_done("t1", 200);
    chk("t1_log_size", uart_log.size(), 32'd2);
    if (uart_log.size() == 2) chk("t1_second_byte", 32'(uart_log[1]), 32'h33);

    // T2: locked message 'A','B' from req0 while req1 waits with 'x'
    uart_log.delete();
    src_q[0].push_back({1'b0, 8'h41});
    src_q[0].push_back({1'b1, 8'h42});
    src_q[1].push_back({1'b1, 8'h78});
    run_until_done("t2", 300);
    chk("t2_log_size", uart_log.size(), 32'd3);
    if (uart_log.size() == 3) begin
      chk("t2_b0", 32'(uart_log[0]), 32'h41);
      chk("t2_b1", 32'(uart_log[1]), 32'h42);
      chk("t2_b2", 32'(uart_log[2]), 32'h78);
    end

    // T3: single-byte messages, both always valid -> strict alternation
    uart_log.delete();
    for (int i = 0; i < 4; i++) begin
      src_q[0].push_back({1'b1, 8'h61});
      src_q[1].push_back({1'b1, 8'h62});
    end
    run_until_done("t3", 500);
    chk("t3_log_size", uart_log.size(), 32'd8);
    c61 = 0; c62 = 0;
    foreach (uart_log[i]) begin
      chk("t3_alternate", 32'(uart_log[i]), (i % 2 == 0) ? 32'h61 : 32'h62);
      if (uart_log[i] == 8'h61) c61++;
      if (uart_log[i] == 8'h62) c62++;
    end
    chk("t3_count_a", c61, 32'd4);
    chk("t3_count_b", c62, 32'd4);

    // T4: single requester, 10-cycle frames, back-to-back bytes
    uart_log.delete();
    frame_len = 10;
    acc0 = acc_cnt[2];
    for (int i = 0; i < 5; i++) begin
      t4_bytes[i] = 8'($urandom_range(8'h20, 8'h7E));
      src_q[2].push_back({1'b1, t4_bytes[i]});
    end
    run_until_done("t4", 500);
    chk("t4_accepts", acc_cnt[2] - acc0, 32'd5);
    chk("t4_log_size", uart_log.size(), 32'd5);
    if (uart_log.size() == 5)
      for (int i = 0; i < 5; i++) chk("t4_byte", 32'(uart_log[i]), 32'(t4_bytes[i]));

    // T5: owner holds lock but goes silent for 50 cycles
    uart_log.delete();
    src_q[0].push_back({1'b0, 8'hC1});
    src_q[1].push_back({1'b1, 8'hD1});
    n = 0;
    while (src_q[0].size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("t5_first_accept", src_q[0].size(), 32'd0);
    en_mask = 3'b110;
    src_q[0].push_back({1'b1, 8'hC2});
    repeat (50) tick();
    chk("t5_one_byte_only", uart_log.size(), 32'd1);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_grant", 32'(grant), 32'b001);
    chk("t5_req1_stalled", src_q[1].size(), 32'd1);
    en_mask = '1;
    run_until_done("t5", 300);
    chk("t5_log_size", uart_log.size(), 32'd3);
    if (uart_log.size() == 3) begin
      chk("t5_b1", 32'(uart_log[1]), 32'hC2);
      chk("t5_b2", 32'(uart_log[2]), 32'hD1);
    end

    // T6: CR byte ending a message, then another requester
    uart_log.delete();
    acc0 = acc_cnt[0];
    src_q[0].push_back({1'b1, 8'h0D});
    src_q[1].push_back({1'b1, 8'h55});
    run_until_done("t6", 300);
    chk("t6_req0_accepts", acc_cnt[0] - acc0, 32'd1);
`ifdef UART_TX_ARB_CRLF_EN
    chk("t6_log_size", uart_log.size(), 32'd3);
    if (uart_log.size() == 3) begin
      chk("t6_cr", 32'(uart_log[0]), 32'h0D);
      chk("t6_lf", 32'(uart_log[1]), 32'h0A);
      chk("t6_next", 32'(uart_log[2]), 32'h55);
    end
`else
    chk("t6_log_size", uart_log.size(), 32'd2);
    if (uart_log.size() == 2) begin
      chk("t6_cr", 32'(uart_log[0]), 32'h0D);
      chk("t6_next", 32'(uart_log[1]), 32'h55);
    end
`endif

    // T7: randomized multi-byte messages with random valid gating
    uart_log.delete();
    frame_len = 3;
    rnd_gate  = 1'b1;
    tot = 0;
    for (int r = 0; r < NR; r++)
      for (int m = 0; m < 10; m++) begin
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) begin
          b = 8'($urandom);
          src_q[r].push_back({(j == len - 1), b});
          tot++;
`ifdef UART_TX_ARB_CRLF_EN
          if (b == 8'h0D) tot++;
`endif
        end
      end
    run_until_done("t7", 20000);
    chk("t7_byte_total", uart_log.size(), tot);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
